// File: rtl/nios_sysid_pkg.sv
// nios_sysid_pkg: shared address map, CONTROL bit positions and bus types
// for the extended system ID peripheral.
package nios_sysid_pkg;

    typedef logic [3:0] addr_t;

    localparam addr_t ADDR_ID         = 4'd0;
    localparam addr_t ADDR_TIMESTAMP  = 4'd1;
    localparam addr_t ADDR_SCRATCH    = 4'd2;
    localparam addr_t ADDR_UPTIME_LO  = 4'd3;
    localparam addr_t ADDR_UPTIME_HI  = 4'd4;
    localparam addr_t ADDR_SECONDS    = 4'd5;
    localparam addr_t ADDR_CONTROL    = 4'd6;
    localparam addr_t ADDR_INFO_COUNT = 4'd7;
    localparam addr_t ADDR_INFO_BASE  = 4'd8;

    localparam int CTRL_CLEAR  = 0;
    localparam int CTRL_FREEZE = 1;
    localparam int CTRL_LOCK   = 7;

endpackage

// File: rtl/nios_sysid_ext_if.sv
// nios_sysid_ext_if: Avalon-MM slave signal bundle (fixed read latency of
// one cycle, no waitrequest).
interface nios_sysid_ext_if;
    import nios_sysid_pkg::*;

    addr_t       address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );

endinterface

// File: rtl/nios_sysid_uptime.sv
// nios_sysid_uptime: free-running uptime counter plus prescaled seconds
// counter. clear wins over any increment; freeze holds all three registers.
module nios_sysid_uptime #(
    parameter int UPTIME_WIDTH = 48,
    parameter int CLK_FREQ_HZ  = 50000000
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    freeze,
    output logic [UPTIME_WIDTH-1:0] uptime,
    output logic [31:0]             seconds
);

    localparam int               PRE_W    = $clog2(CLK_FREQ_HZ);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ_HZ - 1);

    logic [UPTIME_WIDTH-1:0] uptime_q, uptime_d;
    logic [PRE_W-1:0]        prescale_q, prescale_d;
    logic [31:0]             seconds_q, seconds_d;

    // next-state: clear, hold on freeze, otherwise count
    always_comb begin
        uptime_d   = uptime_q;
        prescale_d = prescale_q;
        seconds_d  = seconds_q;
        if (clear) begin
            uptime_d   = '0;
            prescale_d = '0;
            seconds_d  = '0;
        end else if (!freeze) begin
            uptime_d = uptime_q + UPTIME_WIDTH'(1);
            if (prescale_q == PRE_LAST) begin
                prescale_d = '0;
                seconds_d  = seconds_q + 32'd1;
            end else begin
                prescale_d = prescale_q + PRE_W'(1);
            end
        end
    end

    // counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime_q   <= '0;
            prescale_q <= '0;
            seconds_q  <= '0;
        end else begin
            uptime_q   <= uptime_d;
            prescale_q <= prescale_d;
            seconds_q  <= seconds_d;
        end
    end

    assign uptime  = uptime_q;
    assign seconds = seconds_q;

endmodule

// File: rtl/nios_sysid_ext.sv
// nios_sysid_ext: parametrised system ID peripheral with build info table,
// scratch register, uptime/seconds counters and atomic 64-bit uptime readout.
// Optional build macro SYSID_WRITE_LOCK_EN adds a set-only CONTROL.LOCK bit
// that blocks SCRATCH/CONTROL writes until the next reset.
module nios_sysid_ext
    import nios_sysid_pkg::*;
#(
    parameter logic [31:0]  ID_VALUE     = 32'd37,
    parameter logic [31:0]  TIMESTAMP    = 32'd1603647235,
    parameter int           NUM_INFO     = 4,
    parameter logic [255:0] INFO_INIT    = {8{32'h0}},
    parameter int           UPTIME_WIDTH = 48,
    parameter int           CLK_FREQ_HZ  = 50000000
) (
    input  logic              clock,
    input  logic              reset_n,
    nios_sysid_ext_if.slave   bus
);

    logic [31:0]             scratch_q, scratch_d;
    logic [31:0]             hi_snap_q, hi_snap_d;
    logic                    freeze_q, freeze_d;
    logic [31:0]             readdata_q, readdata_d;
    logic                    readdatavalid_q, readdatavalid_d;
    logic                    locked;
    logic                    wr_en, wr_scratch, wr_ctrl, clear;
    logic [2:0]              info_idx;
    logic [31:0]             rd_mux;
    logic [UPTIME_WIDTH-1:0] uptime;
    logic [31:0]             seconds;

`ifdef SYSID_WRITE_LOCK_EN
    logic lock_q, lock_d;

    // LOCK is sticky: only reset clears it, CLEAR does not
    always_comb begin
        lock_d = lock_q | (wr_ctrl & bus.writedata[CTRL_LOCK]);
    end

    // lock register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) lock_q <= 1'b0;
        else          lock_q <= lock_d;
    end

    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    // write decode; a locked peripheral ignores SCRATCH and CONTROL writes
    always_comb begin
        wr_en      = bus.write & ~locked;
        wr_scratch = wr_en && (bus.address == ADDR_SCRATCH);
        wr_ctrl    = wr_en && (bus.address == ADDR_CONTROL);
        clear      = wr_ctrl & bus.writedata[CTRL_CLEAR];
    end

    nios_sysid_uptime #(
        .UPTIME_WIDTH (UPTIME_WIDTH),
        .CLK_FREQ_HZ  (CLK_FREQ_HZ)
    ) u_uptime (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .freeze  (freeze_q),
        .uptime  (uptime),
        .seconds (seconds)
    );

    // read mux from current (pre-write) register values
    always_comb begin
        info_idx = bus.address[2:0];
        rd_mux   = '0;
        case (bus.address)
            ADDR_ID:         rd_mux = ID_VALUE;
            ADDR_TIMESTAMP:  rd_mux = TIMESTAMP;
            ADDR_SCRATCH:    rd_mux = scratch_q;
            ADDR_UPTIME_LO:  rd_mux = uptime[31:0];
            ADDR_UPTIME_HI:  rd_mux = hi_snap_q;
            ADDR_SECONDS:    rd_mux = seconds;
            ADDR_CONTROL: begin
                rd_mux[CTRL_FREEZE] = freeze_q;
                rd_mux[CTRL_LOCK]   = locked;
            end
            ADDR_INFO_COUNT: rd_mux = 32'(NUM_INFO);
            default: begin
                if (bus.address[3] && (int'(info_idx) < NUM_INFO))
                    rd_mux = INFO_INIT[{info_idx, 5'b0} +: 32];
            end
        endcase
    end

    // register next-state; the LO read snapshots the upper uptime bits
    always_comb begin
        scratch_d       = wr_scratch ? bus.writedata : scratch_q;
        freeze_d        = wr_ctrl ? bus.writedata[CTRL_FREEZE] : freeze_q;
        hi_snap_d       = hi_snap_q;
        readdata_d      = readdata_q;
        readdatavalid_d = bus.read;
        if (bus.read) begin
            readdata_d = rd_mux;
            if (bus.address == ADDR_UPTIME_LO)
                hi_snap_d = 32'(uptime[UPTIME_WIDTH-1:32]);
        end
    end

    // register file and read response
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q       <= '0;
            hi_snap_q       <= '0;
            freeze_q        <= 1'b0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            scratch_q       <= scratch_d;
            hi_snap_q       <= hi_snap_d;
            freeze_q        <= freeze_d;
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
        end
    end

    assign bus.readdata      = readdata_q;
    assign bus.readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_nios_sysid_ext.sv
// tb_nios_sysid_ext: directed and randomized checks of nios_sysid_ext
// against a cycle-level behavioural model of the register map.
module tb_nios_sysid_ext;
    import nios_sysid_pkg::*;

    localparam int           F   = 4;
    localparam int           W   = 48;
    localparam int           NI  = 4;
    localparam logic [31:0]  TS  = 32'd1603647235;
    localparam logic [255:0] INFO = {128'h0, 32'hCAFE0004, 32'hCAFE0003,
                                     32'hCAFE0002, 32'hCAFE0001};
    localparam longint unsigned UP_MASK = (64'd1 << W) - 64'd1;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    nios_sysid_ext_if bus();

    nios_sysid_ext #(
        .ID_VALUE     (32'd37),
        .TIMESTAMP    (TS),
        .NUM_INFO     (NI),
        .INFO_INIT    (INFO),
        .UPTIME_WIDTH (W),
        .CLK_FREQ_HZ  (F)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // behavioural model: counted cycles since clear give seconds directly
    longint unsigned m_up, m_cnt;
    logic [31:0]     m_scratch, m_hi, m_rd;
    logic            m_freeze, m_lock, m_rdv;
    logic [255:0]    info_v = INFO;

    function automatic logic [31:0] m_value(input logic [3:0] a);
        int idx;
        case (a)
            4'd0: return 32'd37;
            4'd1: return TS;
            4'd2: return m_scratch;
            4'd3: return m_up[31:0];
            4'd4: return m_hi;
            4'd5: return 32'(m_cnt / 64'(F));
            4'd6: return {24'd0, m_lock, 5'd0, m_freeze, 1'b0};
            4'd7: return 32'(NI);
            default: begin
                idx = int'(a) - 8;
                if (idx >= 0 && idx < NI) return info_v[idx*32 +: 32];
                return 32'd0;
            end
        endcase
    endfunction

    always @(posedge clock or negedge reset_n) begin
        logic [31:0] v;
        logic        adv;
        logic        wok;
        if (!reset_n) begin
            m_up = 0; m_cnt = 0; m_scratch = 0; m_hi = 0; m_rd = 0;
            m_freeze = 0; m_lock = 0; m_rdv = 0;
        end else begin
            v = m_value(bus.address);
            if (bus.read) begin
                m_rd = v;
                if (bus.address == 4'd3) m_hi = 32'(m_up >> 32);
            end
            m_rdv = bus.read;
            wok = bus.write && !m_lock;
            adv = !m_freeze;
            if (wok && bus.address == 4'd2) m_scratch = bus.writedata;
            if (wok && bus.address == 4'd6) begin
                if (bus.writedata[0]) begin
                    m_up = 0; m_cnt = 0; adv = 0;
                end
                m_freeze = bus.writedata[1];
`ifdef SYSID_WRITE_LOCK_EN
                if (bus.writedata[7]) m_lock = 1'b1;
`endif
            end
            if (adv) begin
                m_up  = (m_up + 64'd1) & UP_MASK;
                m_cnt = m_cnt + 64'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one bus cycle, then compare the response against the model
    task automatic step(input logic [3:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd);
        bus.address   = a;
        bus.read      = rd;
        bus.write     = wr;
        bus.writedata = wd;
        @(posedge clock);
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        chk("model_rdv", {31'd0, bus.readdatavalid}, {31'd0, m_rdv});
        chk("model_rd", bus.readdata, m_rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'd0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        logic [3:0]  ra;
        logic        rr, rw;
        logic [31:0] rwd;

        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_rd", bus.readdata, 32'd0);
        chk("reset_rdv", {31'd0, bus.readdatavalid}, 32'd0);
        reset_n = 1'b1;

        // back-to-back ID / TIMESTAMP / INFO_COUNT reads
        step(4'd0, 1'b1, 1'b0, 32'd0);
        chk("id", bus.readdata, 32'd37);
        chk("id_v", {31'd0, bus.readdatavalid}, 32'd1);
        step(4'd1, 1'b1, 1'b0, 32'd0);
        chk("ts", bus.readdata, TS);
        chk("ts_v", {31'd0, bus.readdatavalid}, 32'd1);
        step(4'd7, 1'b1, 1'b0, 32'd0);
        chk("info_count", bus.readdata, 32'd4);
        chk("ic_v", {31'd0, bus.readdatavalid}, 32'd1);
        idle(1);
        chk("rdv_drop", {31'd0, bus.readdatavalid}, 32'd0);
        chk("rd_hold", bus.readdata, 32'd4);

        // scratch, including same-cycle read+write
        step(4'd2, 1'b0, 1'b1, 32'hDEADBEEF);
        step(4'd2, 1'b1, 1'b0, 32'd0);
        chk("scratch", bus.readdata, 32'hDEADBEEF);
        step(4'd2, 1'b1, 1'b1, 32'h1);
        chk("scratch_rw", bus.readdata, 32'hDEADBEEF);
        step(4'd2, 1'b1, 1'b0, 32'd0);
        chk("scratch_new", bus.readdata, 32'h1);

`ifdef SYSID_WRITE_LOCK_EN
        step(4'd6, 1'b0, 1'b1, 32'h80);
        step(4'd2, 1'b0, 1'b1, 32'd5);
        step(4'd2, 1'b1, 1'b0, 32'd0);
        chk("locked_scratch", bus.readdata, 32'h1);
        step(4'd6, 1'b0, 1'b1, 32'h2);
        step(4'd6, 1'b1, 1'b0, 32'd0);
        chk("locked_ctrl", bus.readdata, 32'h80);
`else
        step(4'd6, 1'b0, 1'b1, 32'h80);
        step(4'd6, 1'b1, 1'b0, 32'd0);
        chk("ctrl_bit7", bus.readdata, 32'h0);
`endif

        // reset mid-operation drops a pending response at once
        step(4'd0, 1'b1, 1'b0, 32'd0);
        chk("pre_rst_v", {31'd0, bus.readdatavalid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_drop_v", {31'd0, bus.readdatavalid}, 32'd0);
        chk("rst_drop_rd", bus.readdata, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(1);
        chk("post_rst_v", {31'd0, bus.readdatavalid}, 32'd0);
        step(4'd2, 1'b0, 1'b1, 32'd5);
        step(4'd6, 1'b1, 1'b0, 32'd0);
        chk("ctrl_after_rst", bus.readdata, 32'd0);
        step(4'd2, 1'b1, 1'b0, 32'd0);
        chk("scratch_after_rst", bus.readdata, 32'd5);

        // atomic readout across a carry into bit 32
        step(4'd6, 1'b0, 1'b1, 32'h2);
        force dut.u_uptime.uptime_q = 48'h0000_FFFF_FFFE;
        m_up = 64'h0000_FFFF_FFFE;
        idle(1);
        release dut.u_uptime.uptime_q;
        step(4'd6, 1'b0, 1'b1, 32'h0);
        step(4'd3, 1'b1, 1'b0, 32'd0);
        chk("lo_pre_carry", bus.readdata, 32'hFFFF_FFFE);
        idle(2);
        step(4'd4, 1'b1, 1'b0, 32'd0);
        chk("hi_snapshot", bus.readdata, 32'd0);
        step(4'd3, 1'b1, 1'b0, 32'd0);
        step(4'd4, 1'b1, 1'b0, 32'd0);
        chk("hi_after_carry", bus.readdata, 32'd1);

        // seconds prescaler, freeze and clear
        step(4'd6, 1'b0, 1'b1, 32'h1);
        idle(9);
        step(4'd5, 1'b1, 1'b0, 32'd0);
        chk("seconds_2", bus.readdata, 32'd2);
        step(4'd6, 1'b0, 1'b1, 32'h2);
        idle(20);
        step(4'd5, 1'b1, 1'b0, 32'd0);
        chk("seconds_frozen", bus.readdata, 32'd2);
        step(4'd6, 1'b0, 1'b1, 32'h1);
        step(4'd3, 1'b1, 1'b0, 32'd0);
        chk("lo_small", {31'd0, (bus.readdata < 32'd4)}, 32'd1);
        step(4'd5, 1'b1, 1'b0, 32'd0);
        chk("seconds_clr", bus.readdata, 32'd0);

        // unmapped and info words
        step(4'd15, 1'b1, 1'b0, 32'd0);
        chk("addr15", bus.readdata, 32'd0);
        step(4'd8, 1'b1, 1'b0, 32'd0);
        chk("info0", bus.readdata, 32'hCAFE0001);
        step(4'd11, 1'b1, 1'b0, 32'd0);
        chk("info3", bus.readdata, 32'hCAFE0004);
        step(4'd12, 1'b1, 1'b0, 32'd0);
        chk("info_beyond", bus.readdata, 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            ra  = 4'($urandom_range(0, 15));
            rr  = 1'($urandom_range(0, 1));
            rw  = ($urandom_range(0, 3) == 0);
            rwd = $urandom;
            if (ra == 4'd6) begin
                rwd[0] = ($urandom_range(0, 15) == 0);
                rwd[7] = ($urandom_range(0, 31) == 0);
            end
            step(ra, rr, rw, rwd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_sysid_ext.md
Name: nios_sysid_ext

Overview:
- Parametrised successor to the fixed-ID system ID peripheral on the Nios control bus.
- Avalon-MM slave exposing:
  - ID and build timestamp.
  - A table of build-info words.
  - A software scratch register.
  - A free-running uptime counter with atomic 64-bit readout.
  - A seconds counter.
- Lets firmware check hardware identity and run basic health and liveness checks without extra peripherals.

Parameters:
- ID_VALUE, 32'd37, value returned at word 0
- TIMESTAMP, 32'd1603647235, build timestamp returned at word 1
- NUM_INFO, 4, number of build-info words (1..8)
- INFO_INIT, {8{32'h0}}, packed 256-bit vector; word i = bits [32*i+31:32*i]
- UPTIME_WIDTH, 48, uptime counter width (33..64)
- CLK_FREQ_HZ, 50000000, clock cycles per second tick (>=2)

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  4  word address
- read  in  1  read strobe, one cycle per access
- write  in  1  write strobe
- writedata  in  32  write data
- readdata  out  32  read data, valid when readdatavalid=1
- readdatavalid  out  1  one-cycle pulse, one cycle after read

Behaviour:
- Interface:
  - One clock domain: clock. Reset is asynchronous and active-low: reset_n.
  - No waitrequest; every access is accepted the cycle it is presented.
- Reset values:
  - readdata=0, readdatavalid=0.
  - scratch=0, uptime=0, seconds=0, prescaler=0, hi_snap=0, freeze=0.
- Reads:
  - Fixed latency 1: readdata is registered from the address sampled when read=1; readdatavalid=1 on the next cycle.
  - readdata holds its value when no read is in progress.
- Address map:
  - 0 ID (RO)
  - 1 TIMESTAMP (RO)
  - 2 SCRATCH (RW)
  - 3 UPTIME_LO (RO)
  - 4 UPTIME_HI (RO, snapshot)
  - 5 SECONDS (RO)
  - 6 CONTROL: bit0 CLEAR (write-1 pulse, reads 0), bit1 FREEZE (RW)
  - 7 INFO_COUNT (RO, =NUM_INFO)
  - 8..8+NUM_INFO-1 INFO words (RO)
  - All other addresses read 0; writes to them and to RO words are ignored.
- Uptime counter:
  - Increments by 1 every cycle unless FREEZE=1.
  - Wraps from all-ones to 0.
- Atomic 64-bit readout:
  - A read of UPTIME_LO returns uptime[31:0] and, on the same edge, latches uptime[UPTIME_WIDTH-1:32] (zero-extended) into hi_snap.
  - UPTIME_HI always returns hi_snap, never the live value.
- Seconds counter:
  - Prescaler counts 0..CLK_FREQ_HZ-1. When it reaches CLK_FREQ_HZ-1 it returns to 0 and seconds increments (32-bit, wraps).
  - Both prescaler and seconds hold while FREEZE=1.
- CLEAR:
  - Zeroes uptime, prescaler and seconds on the edge after the write. This overrides any increment in that cycle.
  - hi_snap is not cleared.
- Simultaneous events:
  - read=1 and write=1 on the same cycle: the write is applied, and the read returns the pre-write value.
  - Read of UPTIME_LO in the same cycle as a CLEAR write: returns the pre-clear value; hi_snap takes the pre-clear upper bits.
- Reset mid-operation: any pending readdatavalid is dropped immediately (asynchronous); no partial response follows reset release.

Optional Feature:
- SYSID_WRITE_LOCK_EN defined:
  - CONTROL bit7 LOCK is set-only. Once 1, writes to SCRATCH and CONTROL are ignored until reset_n is asserted.
  - LOCK reads back as 1 and survives CLEAR.
- Undefined: bit7 reads 0, and writes always take effect.

Decomposition:
- Package nios_sysid_pkg holds:
  - Address constants ADDR_ID..ADDR_INFO_BASE.
  - CONTROL bit indices (CLEAR=0, FREEZE=1, LOCK=7).
  - The 4-bit address type.
- One sub-module, nios_sysid_uptime:
  - Owns the uptime counter, prescaler and seconds counter.
  - Inputs: clear, freeze.
  - Outputs: uptime, seconds.

Test Plan:
- Reset, then read addresses 0, 1 and 7 back-to-back -> readdata 37, 1603647235, 4, each with readdatavalid one cycle after its read, three consecutive pulses.
- Write SCRATCH=32'hDEADBEEF, then read it -> 32'hDEADBEEF. Same-cycle write 32'h1 with read -> returns 32'hDEADBEEF; the next read returns 1.
- UPTIME_WIDTH=48, force uptime to 48'h0000_FFFF_FFFE via a FREEZE/CLEAR sequence plus wait, read LO and then HI 3 cycles later -> HI equals the upper bits captured at the LO read, not bits after carry.
- CLK_FREQ_HZ=4, wait 9 cycles after reset, read SECONDS -> 2. Set FREEZE, wait 20 cycles -> still 2. Write CLEAR -> UPTIME_LO reads small post-clear count; SECONDS reads 0.
- Read address 15 and INFO[0] with INFO_INIT word0=32'hCAFE0001 -> 0 and 32'hCAFE0001.
- With SYSID_WRITE_LOCK_EN: write CONTROL=32'h80, then SCRATCH=5 -> SCRATCH unchanged, CONTROL reads bit7=1. Pulse reset_n -> LOCK=0 and writes take effect again.
